// File: rtl/slave_port.sv
// slave_port: serial-bus responder that deserialises requests for one parallel slave and serialises read data back
module slave_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  sp_valid,
  input  logic                  sp_mode,
  input  logic                  sp_addr,
  input  logic                  sp_wdata,
  output logic                  sp_ready,
  output logic                  sp_rdata,
  output logic                  sp_rvalid,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [DATA_WIDTH-1:0] s_wdata,
  output logic                  s_mode,
  output logic                  s_valid,
  input  logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic                  s_rvalid
);
  localparam int CW = $clog2(ADDR_WIDTH) + 1;
  typedef enum logic [2:0] {IDLE, RX, REQ, RWAIT, TX} state_t;
  state_t                state;
  logic [CW-1:0]         cnt;
  logic [ADDR_WIDTH-1:0] addr_sr, addr_nx;
  logic [DATA_WIDTH-1:0] wdata_sr, wdata_nx, tx_sr;
  logic                  mode;
  // wdata bits beyond the byte shift out of range and vanish, so only the first 8 cycles land
  always_comb begin
    addr_nx  = addr_sr | (ADDR_WIDTH'(sp_addr) << cnt);
    wdata_nx = wdata_sr | (DATA_WIDTH'(sp_wdata) << cnt);
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_sr   <= '0;
      wdata_sr  <= '0;
      tx_sr     <= '0;
      mode      <= 1'b0;
      sp_ready  <= 1'b1;
      sp_rdata  <= 1'b0;
      sp_rvalid <= 1'b0;
      s_addr    <= '0;
      s_wdata   <= '0;
      s_mode    <= 1'b0;
      s_valid   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (sp_valid) begin
          state    <= RX;
          mode     <= sp_mode;
          addr_sr  <= ADDR_WIDTH'(sp_addr);
          wdata_sr <= DATA_WIDTH'(sp_wdata);
          cnt      <= CW'(1);
          sp_ready <= 1'b0;
        end
        RX: if (!sp_valid) begin
          state    <= IDLE;
          sp_ready <= 1'b1;
          addr_sr  <= '0;
          wdata_sr <= '0;
          cnt      <= '0;
        end else if (cnt == CW'(ADDR_WIDTH - 1)) begin
          state   <= REQ;
          s_valid <= 1'b1;
          s_addr  <= addr_nx;
          s_wdata <= wdata_nx;
          s_mode  <= mode;
        end else begin
          addr_sr  <= addr_nx;
          wdata_sr <= wdata_nx;
          cnt      <= cnt + CW'(1);
        end
        REQ: if (s_ready) begin
          s_valid  <= 1'b0;
          state    <= s_mode ? IDLE : RWAIT;
          sp_ready <= s_mode;
        end
        RWAIT: if (s_rvalid) begin
          state     <= TX;
          tx_sr     <= s_rdata >> 1;
          sp_rdata  <= s_rdata[0];
          sp_rvalid <= 1'b1;
          cnt       <= CW'(1);
        end
        TX: if (cnt == CW'(DATA_WIDTH)) begin
          state     <= IDLE;
          sp_rvalid <= 1'b0;
          sp_rdata  <= 1'b0;
          sp_ready  <= 1'b1;
        end else begin
          sp_rdata <= tx_sr[0];
          tx_sr    <= tx_sr >> 1;
          cnt      <= cnt + CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
